mux8_rr_arbiter: RTL
====================

Name: mux8_rr_arbiter

Overview:
- Round-robin scheduler that shares the 8:1 single-bit mux (mux8to1) between 8 requesters. Requester i owns input din[i].
- Picks one requester, drives the mux select, and streams up to MAX_BURST beats from that requester to a downstream ready/valid sink. It then rotates priority.
- Sits between requester agents and the consumer of y; instantiates mux8to1 internally.

Parameters:
- MAX_BURST, 4, maximum accepted beats per grant; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  8  request per requester; must stay high while a requester wants beats
- din  input  8  per-requester data bit; drives the mux inputs
- out_ready  input  1  downstream can accept a beat this cycle
- gnt  output  8  one-hot grant, registered; 8'h00 when idle
- sel  output  3  mux select, registered; equals the index of the set gnt bit
- y  output  1  mux output din[sel] while granted, else 0
- y_valid  output  1  beat valid
- busy  output  1  high in state GRANT

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, ptr=0, gnt=8'h00, sel=3'd0, beat_cnt=0.
  - Outputs in the cycle after reset: y=0, y_valid=0, busy=0.
  - rst has priority over all other events, including mid-burst; any grant in progress is dropped with no further beats.
- State IDLE:
  - If req!=0, select the winner W. W is the first set req bit searching upward from ptr, wrapping 7->0.
  - At the next edge: gnt=1<<W, sel=W, beat_cnt=0, state=GRANT. Grant latency is 1 cycle from req.
- State GRANT:
  - y_valid = req[sel] (combinational); y = din[sel] via the mux.
  - A transfer occurs in a cycle where y_valid && out_ready.
  - Transfer and beat_cnt < MAX_BURST-1: beat_cnt increments and the grant holds.
  - Release condition A: transfer with beat_cnt == MAX_BURST-1 (burst limit reached).
  - Release condition B: req[sel]==0. No transfer occurs that cycle; the requester abandons its remaining beats.
  - out_ready=0 with req[sel]=1: no transfer. gnt, sel and beat_cnt hold for an unbounded number of cycles.
- On release in cycle t:
  - ptr <= sel+1 modulo 8 (7 wraps to 0).
  - Re-arbitration runs in the same cycle from the new pointer value (sel+1) against the current req.
  - The released requester has lowest priority but may win again if it is the only requester.
  - If a winner exists: at t+1 gnt/sel switch to it with beat_cnt=0 and state stays GRANT. There is no bubble cycle.
  - If no winner: at t+1 gnt=0 and state=IDLE.
- beat_cnt width: max(1, clog2(MAX_BURST)). MAX_BURST=1 gives exactly one beat per grant.
- Changes on req[j] for j!=sel never disturb the current grant.
- gnt is always zero or one-hot; sel changes only together with gnt.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF, out_ready=1 -> gnt=8'h00, sel=0, y=0, y_valid=0, busy=0 throughout. First grant is 8'h01 one cycle after rst falls.
- Single requester: req=8'h08, din=8'h08, out_ready=1, MAX_BURST=4 -> one cycle later gnt=8'h08, sel=3, y=1, y_valid=1. After 4 transfers the grant is re-issued to 3 with no idle cycle, with beat_cnt restarting at 0.
- Rotation: req=8'hFF held, out_ready=1 -> sel sequence 0,1,2,...,7,0 with exactly 4 transfers each. gnt is one-hot every cycle and has no gaps.
- Wrap and priority: grant to 7 completes while req=8'h81 -> next grant is 0 (gnt=8'h01), then 7, alternating.
- Backpressure and early release:
  - During a grant to 2, drop out_ready for 3 cycles after beat 1 -> gnt=8'h04 held and beat_cnt frozen; exactly 4 transfers in total.
  - Separately, drop req[2] after 2 transfers while req=8'h20 -> the next cycle shows gnt=8'h20, sel=5.
- Reset mid-burst: assert rst for 1 cycle during beat 2 of a grant to 6 -> the next cycle shows gnt=0, y_valid=0. With req=8'h40 still high, the following cycle re-grants to 6 with ptr having reset to 0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin scheduler sharing one 8:1 single-bit mux between 8 requesters.
// Streams up to MAX_BURST beats per grant to a ready/valid sink, then rotates priority.

module mux8to1 (
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       y
);
  assign y = d[s];
endmodule

module mux8_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] din,
  input  logic       out_ready,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       y,
  output logic       y_valid,
  output logic       busy
);

  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [7:0]      gnt_q, gnt_d;
  logic [2:0]      sel_q, sel_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic            mux_y;
  logic            granted;
  logic            xfer;
  logic            last_beat;
  logic [2:0]      base;
  logic [2:0]      idx;
  logic            found;
  logic [2:0]      win;

  mux8to1 u_mux (
    .d (din),
    .s (sel_q),
    .y (mux_y)
  );

  assign granted   = (state_q == GRANT);
  assign y_valid   = granted & req[sel_q];
  assign y         = granted & mux_y;
  assign xfer      = y_valid & out_ready;
  assign last_beat = (beat_q == BW'(MAX_BURST - 1));
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = granted;

  // Winner search; on release the search starts just past the outgoing owner
  always_comb begin
    base  = granted ? (sel_q + 3'd1) : ptr_q;
    found = 1'b0;
    win   = base;
    idx   = base;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 8'h01 << win;
          sel_d   = win;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q] || (xfer && last_beat)) begin
          ptr_d  = sel_q + 3'd1;
          beat_d = '0;
          if (found) begin
            gnt_d = 8'h01 << win;
            sel_d = win;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
          end
        end else if (xfer) begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
    end
  end

endmodule
